// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_STEP           = 32'd4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > clear (bubble) > hold > load.
// One-cycle latency from pc_in/instr_in to outputs; hold freezes contents.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/HALTED FSM, fetch counter and IF/ID register.
// Priority in RUN is flush > halt > stall > normal; HALTED freezes everything until reset.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        halt_coman,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         ifid_hold;
    logic         ifid_clear;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        ifid_hold  = 1'b1;
        ifid_clear = 1'b0;
        if (state_q == RUN) begin
            if (flush) begin
                pc_d       = {redirect_pc[31:2], 2'b00};
                ifid_clear = 1'b1;
            end else if (halt_coman) begin
                ifid_clear = 1'b1;
                state_d    = HALTED;
            end else if (!stall) begin
                // PC wraps naturally; the counter sticks at all-ones
                pc_d      = pc_q + PC_STEP;
                ifid_hold = 1'b0;
                if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .hold_i  (ifid_hold),
        .clear_i (ifid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .pc_o    (if_id_pc),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = cnt_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID.
REQ-003 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 stall  in  1  hold PC and IF/ID (from hazard unit).
REQ-006 flush  in  1  branch taken / jal / jalr resolved; redirect fetch.
REQ-007 redirect_pc  in  32  target PC, valid when flush=1.
REQ-008 halt_coman  in  1  HALT opcode decoded in ID stage.
REQ-009 imem_rdata  in  32  instruction word at imem_addr, combinational read.
REQ-010 imem_addr  out  32  current PC to instruction memory.
REQ-011 if_id_pc  out  32  PC of instruction held in IF/ID.
REQ-012 if_id_instr  out  32  instruction held in IF/ID; its [6:0] feeds the decode controller opcode.
REQ-013 if_id_valid  out  1  IF/ID holds a real fetched instruction.
REQ-014 halted  out  1  fetch permanently stopped.
REQ-015 fetch_count  out  32  number of instructions written valid into IF/ID.

Function
REQ-016 imem_addr SHALL equal the PC register combinationally; PC[1:0] SHALL always be 0.
REQ-017 State machine SHALL have two states: RUN, HALTED.
REQ-018 Per-cycle priority in RUN SHALL be flush > halt_coman > stall > normal.
REQ-019 Normal: PC <= PC+4; IF/ID <= {PC, imem_rdata, valid=1}; fetch_count += 1.
REQ-020 Stall: PC, IF/ID, fetch_count SHALL hold.
REQ-021 Flush: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= {0, NOP_INSTR, valid=0}; fetch_count holds; stall ignored.
REQ-022 halt_coman (no flush): PC holds; IF/ID <= {0, NOP_INSTR, valid=0}; state -> HALTED next edge.
REQ-023 Flush with halt_coman same cycle: flush wins (HALT is squashed); state stays RUN.
REQ-024 HALTED: stall, flush, halt_coman, imem_rdata ignored; all registers hold; halted=1; exit only via reset.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-027 Latency: instruction at imem_addr in cycle N SHALL appear on if_id_instr in cycle N+1 when not stalled/flushed.

Reset
REQ-028 On clk edge with reset=0: PC=RESET_PC, state=RUN, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0, fetch_count=0.
REQ-029 Reset SHALL override all other inputs, including in HALTED and mid-stall.
REQ-030 First fetch SHALL occur on the first edge with reset=1.

Structure
REQ-031 Shared package SHALL hold fetch_state_t (RUN, HALTED), NOP_INSTR default, PC_STEP=4.
REQ-032 IF/ID register with hold/clear SHALL be a sub-module named if_id_reg; PC logic, FSM, counter stay in fetch_stage.

Verification
REQ-033 Reset release, imem returns addr-indexed words -> imem_addr 0,4,8; if_id_pc 0,4 one cycle later; fetch_count 1,2,3.
REQ-034 stall=1 for 2 cycles at PC=8 -> imem_addr stays 8, IF/ID holds pc=4, fetch_count unchanged, resumes at 12.
REQ-035 flush=1, redirect_pc=32'h0000_0103 at PC=16 -> next imem_addr=32'h100, if_id_instr=32'h13, valid=0.
REQ-036 halt_coman=1 at PC=20 -> halted=1 next cycle, imem_addr frozen at 20; later flush/stall pulses change nothing; reset=0 restores PC=0, halted=0.
REQ-037 flush=1 and halt_coman=1 same cycle, redirect_pc=32'h40 -> halted stays 0, imem_addr=32'h40.
REQ-038 RESET_PC=32'hFFFF_FFF8, run 3 cycles -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
